// File: rtl/seq_mult_unit.sv
// Multi-cycle shift-and-add multiplier: one partial-product add per clock through
// a chain of 4-bit carry-lookahead adders, then a sign-fix cycle before done.

module cla4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c;
endmodule

module seq_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int NC = WIDTH / 4;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  // The top bit of the WIDTH+1-bit accumulator is always 0 after each shift, so only
  // the low WIDTH bits are stored; the adder carry supplies bit WIDTH of each sum.
  logic [WIDTH-1:0]   a_q, a_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH-1:0]   cla_sum;
  logic [NC:0]        carry;
  logic [WIDTH:0]     s;
  logic [2*WIDTH-1:0] p_full;
  logic [2*WIDTH-1:0] p_neg;

  // Most negative operand maps to 2^(WIDTH-1), which is still correct as unsigned.
  assign abs1 = (signed_op && in1[WIDTH-1]) ? (~in1 + WIDTH'(1)) : in1;
  assign abs2 = (signed_op && in2[WIDTH-1]) ? (~in2 + WIDTH'(1)) : in2;

  assign carry[0] = 1'b0;
  for (genvar i = 0; i < NC; i++) begin : g_cla
    cla4bit u_cla (
      .a_i (a_q[4*i +: 4]),
      .b_i (m_q[4*i +: 4]),
      .c_i (carry[i]),
      .s_o (cla_sum[4*i +: 4]),
      .c_o (carry[i+1])
    );
  end

  assign s      = q_q[0] ? {carry[NC], cla_sum} : {1'b0, a_q};
  assign p_full = {a_q, q_q};
  assign p_neg  = ~p_full + (2*WIDTH)'(1);

  // NOTE: every next-state signal gets its hold value first so no path through the
  // case statement leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = abs1;
          q_d     = abs2;
          a_d     = '0;
          cnt_d   = CW'(WIDTH);
          neg_d   = signed_op & (in1[WIDTH-1] ^ in2[WIDTH-1]);
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = s[WIDTH:1];
        q_d   = {s[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        {hi_d, lo_d} = neg_q ? p_neg : p_full;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign product_hi = hi_q;
  assign product_lo = lo_q;
endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
Multi-cycle shift-and-add multiplier for the single-cycle RISC datapath. It serves MUL/MULH-class instructions.
- Each iteration's partial-sum addition is done by a chain of WIDTH/4 CLA4BIT adders. The CLA produces the sum; this block registers it, shifts it and sequences the iterations.
- The control unit stalls the PC while busy is high, then consumes product_hi/product_lo on done.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 4 (one CLA4BIT per nibble).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a multiply; sampled only in IDLE
signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
in1  input  WIDTH  multiplicand; sampled with start
in2  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when the product is valid
product_hi  output  WIDTH  upper half of the 2*WIDTH-bit product
product_lo  output  WIDTH  lower half of the 2*WIDTH-bit product

Behaviour:
Interface:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- rst_n low forces: state=IDLE; busy=0; done=0; product_hi=0; product_lo=0; all internal registers=0. Reset is honoured mid-operation; the partial result is discarded.

States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - M <= |in1|, Q <= |in2| (absolute value only when signed_op=1; otherwise raw values).
  - A <= 0 (WIDTH+1 bits); cnt <= WIDTH.
  - neg <= signed_op & (in1[MSB] ^ in2[MSB]).
  - busy <= 1; go to CALC.
- IDLE, start=0: hold; outputs keep their last values.
- CALC, each edge:
  - If Q[0]=1: S = A[WIDTH-1:0] + M via the CLA chain, carry-in 0, final carry_out forming bit WIDTH. Otherwise S = {1'b0, A[WIDTH-1:0]}.
  - {A,Q} <= {S,Q} >> 1 (logical shift, 2*WIDTH+1 bits); cnt <= cnt-1.
  - When cnt reaches 1, the transition goes to FIX after this iteration.
  - Exactly WIDTH iterations occur: edges E1..E_WIDTH.
- FIX, one edge (E_WIDTH+1):
  - P = {A[WIDTH-1:0], Q}.
  - If neg: {product_hi, product_lo} <= ~P + 1 (2*WIDTH-bit two's complement, wraps). Otherwise <= P.
  - busy <= 0; done <= 1; go to IDLE.
- done is high for exactly one cycle, after edge E_WIDTH+1. It deasserts on the next edge unless reset.

Latency and handshake:
- Start-to-done latency is WIDTH+1 clocks; 33 for WIDTH=32.
- start while busy=1 is ignored entirely: no restart, no queuing.
- start in the cycle where done=1 (state already IDLE) is accepted: back-to-back operation.
- Product outputs change only in FIX. They hold stable from done until the next FIX or reset.

Arithmetic and boundaries:
- The magnitude of the most negative value (0x80..0) is taken as the unsigned value 2^(WIDTH-1); the result is still correct.
- Operand of 0: the product is 0 and neg is irrelevant, since negating 0 gives 0.
- The unsigned product never overflows 2*WIDTH bits.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> busy=0, done=0, product_hi=product_lo=0x00000000. start=0 for 10 cycles -> no change.
- Unsigned small: in1=7, in2=6, signed_op=0, start pulse -> busy high 33 cycles; done pulses once exactly 33 clocks after the start edge; product_hi=0x00000000, product_lo=0x0000002A.
- Unsigned max vs signed: in1=in2=0xFFFFFFFF, signed_op=0 -> hi=0xFFFFFFFE, lo=0x00000001. Same operands with signed_op=1 (-1*-1) -> hi=0x00000000, lo=0x00000001.
- Signed mixed and edge values:
  - in1=0xFFFFFFFD (-3), in2=5, signed_op=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - in1=in2=0x80000000, signed_op=1 -> hi=0x40000000, lo=0x00000000.
  - in1=0xFFFFFFFF, in2=2, signed_op=0 -> hi=0x00000001, lo=0xFFFFFFFE.
- Start while busy: start 7*6, then at cycle 10 pulse start with in1=in2=9 -> ignored; result 0x2A at cycle 33. A new start in the done cycle (9*9) -> done 33 cycles later with lo=0x00000051.
- Reset mid-operation: start 7*6, assert rst_n=0 asynchronously (between edges) at cycle 15 -> busy, done and products go 0 immediately; after release no done pulse occurs until a new start.
